// File: rtl/id_ex_decode_stage_pkg.sv
// Shared MIPS decode constants: ALU op codes, opcode/funct/REGIMM encodings and operand selects.
// The EX-stage ALU imports the same package so both ends agree on the op code values.
package id_ex_decode_stage_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_AND  = 5'b00001;
    localparam logic [4:0] ALU_XOR  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_NOR  = 5'b00100;
    localparam logic [4:0] ALU_SUB  = 5'b00101;
    localparam logic [4:0] ALU_ANDI = 5'b00110;
    localparam logic [4:0] ALU_XORI = 5'b00111;
    localparam logic [4:0] ALU_ORI  = 5'b01000;
    localparam logic [4:0] ALU_JR   = 5'b01001;
    localparam logic [4:0] ALU_BEQ  = 5'b01010;
    localparam logic [4:0] ALU_BNE  = 5'b01011;
    localparam logic [4:0] ALU_BGEZ = 5'b01100;
    localparam logic [4:0] ALU_BGTZ = 5'b01101;
    localparam logic [4:0] ALU_BLEZ = 5'b01110;
    localparam logic [4:0] ALU_BLTZ = 5'b01111;
    localparam logic [4:0] ALU_SLL  = 5'b10000;
    localparam logic [4:0] ALU_SRL  = 5'b10001;
    localparam logic [4:0] ALU_SRA  = 5'b10010;
    localparam logic [4:0] ALU_SLT  = 5'b10011;
    localparam logic [4:0] ALU_SLTU = 5'b10100;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [4:0] RI_BLTZ = 5'd0;
    localparam logic [4:0] RI_BGEZ = 5'd1;

    typedef enum logic [1:0] {A_RS, A_SHAMT, A_ZERO, A_PC4} a_sel_e;
    typedef enum logic [1:0] {B_RT, B_SIMM, B_LUI, B_FOUR} b_sel_e;

endpackage

// File: rtl/id_ex_decode_stage_alu_ctrl_decode.sv
// Combinational instruction decode: ALU op code, operand selects, destination and control bits.
// A non-writing instruction reports dst=0 so downstream hazard logic never matches it.
module id_ex_decode_stage_alu_ctrl_decode
    import id_ex_decode_stage_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    output logic [4:0]        alu_code,
    output a_sel_e            a_sel,
    output b_sel_e            b_sel,
    output logic [REG_AW-1:0] dst,
    output logic              writes,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ovf_trap,
    output logic              uses_rs,
    output logic              uses_rt,
    output logic              illegal
);

    always_comb begin
        alu_code  = ALU_ADD;
        a_sel     = A_RS;
        b_sel     = B_RT;
        dst       = '0;
        writes    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ovf_trap  = 1'b0;
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                writes  = 1'b1;
                dst     = REG_AW'(rd);
                case (funct)
                    FN_SLL:  begin alu_code = ALU_SLL; a_sel = A_SHAMT; uses_rs = 1'b0; end
                    FN_SRL:  begin alu_code = ALU_SRL; a_sel = A_SHAMT; uses_rs = 1'b0; end
                    FN_SRA:  begin alu_code = ALU_SRA; a_sel = A_SHAMT; uses_rs = 1'b0; end
                    FN_SLLV: alu_code = ALU_SLL;
                    FN_SRLV: alu_code = ALU_SRL;
                    FN_SRAV: alu_code = ALU_SRA;
                    FN_JR:   begin alu_code = ALU_JR; writes = 1'b0; dst = '0; end
                    FN_ADD:  begin alu_code = ALU_ADD; ovf_trap = 1'b1; end
                    FN_ADDU: alu_code = ALU_ADD;
                    FN_SUB:  begin alu_code = ALU_SUB; ovf_trap = 1'b1; end
                    FN_SUBU: alu_code = ALU_SUB;
                    FN_AND:  alu_code = ALU_AND;
                    FN_OR:   alu_code = ALU_OR;
                    FN_XOR:  alu_code = ALU_XOR;
                    FN_NOR:  alu_code = ALU_NOR;
                    FN_SLT:  alu_code = ALU_SLT;
                    FN_SLTU: alu_code = ALU_SLTU;
                    default: begin
                        illegal = 1'b1;
                        writes  = 1'b0;
                        dst     = '0;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                    end
                endcase
            end
            OP_REGIMM: begin
                uses_rs = 1'b1;
                case (rt)
                    RI_BLTZ: alu_code = ALU_BLTZ;
                    RI_BGEZ: alu_code = ALU_BGEZ;
                    default: begin illegal = 1'b1; uses_rs = 1'b0; end
                endcase
            end
            OP_J: ;
            OP_JAL: begin
                a_sel  = A_PC4;
                b_sel  = B_FOUR;
                writes = 1'b1;
                dst    = REG_AW'(LINK_REG);
            end
            OP_BEQ:  begin alu_code = ALU_BEQ;  uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BNE:  begin alu_code = ALU_BNE;  uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BLEZ: begin alu_code = ALU_BLEZ; uses_rs = 1'b1; end
            OP_BGTZ: begin alu_code = ALU_BGTZ; uses_rs = 1'b1; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                b_sel    = B_SIMM;
                uses_rs  = 1'b1;
                writes   = 1'b1;
                dst      = REG_AW'(rt);
                ovf_trap = (opcode == OP_ADDI);
                case (opcode)
                    OP_SLTI:  alu_code = ALU_SLT;
                    OP_SLTIU: alu_code = ALU_SLTU;
                    OP_ANDI:  alu_code = ALU_ANDI;
                    OP_ORI:   alu_code = ALU_ORI;
                    OP_XORI:  alu_code = ALU_XORI;
                    default:  alu_code = ALU_ADD;
                endcase
            end
            OP_LUI: begin
                a_sel  = A_ZERO;
                b_sel  = B_LUI;
                writes = 1'b1;
                dst    = REG_AW'(rt);
            end
            OP_LW: begin
                b_sel    = B_SIMM;
                uses_rs  = 1'b1;
                mem_read = 1'b1;
                writes   = 1'b1;
                dst      = REG_AW'(rt);
            end
            OP_SW: begin
                b_sel     = B_SIMM;
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
                mem_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_decode_stage.sv
// ID-stage decode plus ID/EX pipeline register with flush, hold and load-use bubble insertion.
// Operand muxes and hazard detection live here; the instruction decode is in the sub-module.
module id_ex_decode_stage
    import id_ex_decode_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [4:0]        ex_alu_code,
    output logic [DATA_W-1:0] ex_alu_a,
    output logic [DATA_W-1:0] ex_alu_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dst_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_ovf_trap,
    output logic              ex_illegal
);

    logic [4:0]        rs_f, rt_f, shamt;
    logic [15:0]       imm;
    logic [4:0]        dec_code;
    a_sel_e            a_sel;
    b_sel_e            b_sel;
    logic [REG_AW-1:0] dec_dst;
    logic              dec_writes, dec_mem_read, dec_mem_write, dec_ovf, dec_illegal;
    logic              uses_rs, uses_rt, hazard;
    logic [DATA_W-1:0] alu_a, alu_b;

    assign rs_f  = id_instr[25:21];
    assign rt_f  = id_instr[20:16];
    assign shamt = id_instr[10:6];
    assign imm   = id_instr[15:0];

    id_ex_decode_stage_alu_ctrl_decode #(
        .REG_AW   (REG_AW),
        .LINK_REG (LINK_REG)
    ) u_dec (
        .opcode    (id_instr[31:26]),
        .funct     (id_instr[5:0]),
        .rt        (rt_f),
        .rd        (id_instr[15:11]),
        .alu_code  (dec_code),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .dst       (dec_dst),
        .writes    (dec_writes),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .ovf_trap  (dec_ovf),
        .uses_rs   (uses_rs),
        .uses_rt   (uses_rt),
        .illegal   (dec_illegal)
    );

    always_comb begin
        alu_a = id_rs_data;
        case (a_sel)
            A_SHAMT: alu_a = {{(DATA_W-5){1'b0}}, shamt};
            A_ZERO:  alu_a = '0;
            A_PC4:   alu_a = id_pc_plus4;
            default: alu_a = id_rs_data;
        endcase
    end

    always_comb begin
        alu_b = id_rt_data;
        case (b_sel)
            B_SIMM:  alu_b = {{(DATA_W-16){imm[15]}}, imm};
            B_LUI:   alu_b = DATA_W'({imm, 16'h0000});
            B_FOUR:  alu_b = DATA_W'(32'd4);
            default: alu_b = id_rt_data;
        endcase
    end

    // A load to $0 never produces a value worth waiting for.
    assign hazard = ex_valid && ex_mem_read && (ex_dst_reg != '0) && id_valid &&
                    ((uses_rs && (REG_AW'(rs_f) == ex_dst_reg)) ||
                     (uses_rt && (REG_AW'(rt_f) == ex_dst_reg)));
    assign hazard_stall = hazard && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_alu_code   <= ALU_ADD;
            ex_alu_a      <= '0;
            ex_alu_b      <= '0;
            ex_store_data <= '0;
            ex_dst_reg    <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_ovf_trap   <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (flush || (!ex_hold && hazard)) begin
            // Bubble: enables cleared, datapath follows ID so it stays deterministic.
            ex_valid      <= 1'b0;
            ex_alu_code   <= dec_code;
            ex_alu_a      <= alu_a;
            ex_alu_b      <= alu_b;
            ex_store_data <= id_rt_data;
            ex_dst_reg    <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_ovf_trap   <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (!ex_hold) begin
            ex_valid      <= id_valid;
            ex_alu_code   <= dec_code;
            ex_alu_a      <= alu_a;
            ex_alu_b      <= alu_b;
            ex_store_data <= id_rt_data;
            ex_dst_reg    <= dec_dst;
            ex_reg_write  <= id_valid && dec_writes && (dec_dst != '0);
            ex_mem_read   <= id_valid && dec_mem_read;
            ex_mem_write  <= id_valid && dec_mem_write;
            ex_ovf_trap   <= id_valid && dec_ovf;
            ex_illegal    <= id_valid && dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Directed bench for id_ex_decode_stage: a decode vector table plus hand-written
// sequences for reset, load-use stalls, hold, flush and asynchronous reset.
module tb_id_ex_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic [31:0] id_pc_plus4 = '0;
    logic [31:0] id_rs_data = '0;
    logic [31:0] id_rt_data = '0;
    logic        ex_hold = 1'b0;
    logic        flush = 1'b0;
    logic        hazard_stall;
    logic        ex_valid;
    logic [4:0]  ex_alu_code;
    logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [4:0]  ex_dst_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_ovf_trap, ex_illegal;

    int checks = 0;
    int errors = 0;

    id_ex_decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc_plus4   (id_pc_plus4),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .ex_hold       (ex_hold),
        .flush         (flush),
        .hazard_stall  (hazard_stall),
        .ex_valid      (ex_valid),
        .ex_alu_code   (ex_alu_code),
        .ex_alu_a      (ex_alu_a),
        .ex_alu_b      (ex_alu_b),
        .ex_store_data (ex_store_data),
        .ex_dst_reg    (ex_dst_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_ovf_trap   (ex_ovf_trap),
        .ex_illegal    (ex_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] instr, rs_d, rt_d, pc4;
        logic [4:0]  code;
        logic        chk_ab;
        logic [31:0] a, b;
        logic [4:0]  dst;
        logic        rw, mr, mw, ovf, ill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic vec_t mk(string n, logic [31:0] ins, logic [31:0] rs_d, logic [31:0] rt_d,
                                logic [31:0] pc4, logic [4:0] code, logic chk_ab, logic [31:0] a,
                                logic [31:0] b, logic [4:0] dst, logic rw, logic mr, logic mw,
                                logic ovf, logic ill);
        vec_t v;
        v.name = n; v.instr = ins; v.rs_d = rs_d; v.rt_d = rt_d; v.pc4 = pc4;
        v.code = code; v.chk_ab = chk_ab; v.a = a; v.b = b; v.dst = dst;
        v.rw = rw; v.mr = mr; v.mw = mw; v.ovf = ovf; v.ill = ill;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [31:0] ins, logic [31:0] rs_d, logic [31:0] rt_d, logic [31:0] pc4);
        id_valid    = 1'b1;
        id_instr    = ins;
        id_rs_data  = rs_d;
        id_rt_data  = rt_d;
        id_pc_plus4 = pc4;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_instr = '0;
        tick();
    endtask

    initial begin
        //          name        instr                      rs_d          rt_d          pc4       code      ab a             b             dst rw mr mw ov il
        vecs.push_back(mk("sll",     r_ins(0, 2, 3, 4, 'h00),  32'hAAAA,     32'h1,        32'h0,    5'b10000, 1, 32'h4,        32'h1,        3,  1, 0, 0, 0, 0));
        vecs.push_back(mk("addi",    i_ins('h08, 0, 5, 'hFFFF), 32'h0,       32'h77,       32'h0,    5'b00000, 1, 32'h0,        32'hFFFFFFFF, 5,  1, 0, 0, 1, 0));
        vecs.push_back(mk("lui",     i_ins('h0F, 0, 6, 'h1234), 32'h55,      32'h0,        32'h0,    5'b00000, 1, 32'h0,        32'h12340000, 6,  1, 0, 0, 0, 0));
        vecs.push_back(mk("sub",     r_ins(9, 10, 8, 0, 'h22), 32'd100,      32'd30,       32'h0,    5'b00101, 1, 32'd100,      32'd30,       8,  1, 0, 0, 1, 0));
        vecs.push_back(mk("subu",    r_ins(9, 10, 8, 0, 'h23), 32'd100,      32'd30,       32'h0,    5'b00101, 1, 32'd100,      32'd30,       8,  1, 0, 0, 0, 0));
        vecs.push_back(mk("srav",    r_ins(12, 13, 11, 0, 'h07), 32'h3,      32'h80000000, 32'h0,    5'b10010, 1, 32'h3,        32'h80000000, 11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("ori",     i_ins('h0D, 3, 2, 'h8001), 32'h10,      32'h99,       32'h0,    5'b01000, 1, 32'h10,       32'hFFFF8001, 2,  1, 0, 0, 0, 0));
        vecs.push_back(mk("andi",    i_ins('h0C, 1, 2, 'h00FF), 32'h1234,    32'h0,        32'h0,    5'b00110, 1, 32'h1234,     32'hFF,       2,  1, 0, 0, 0, 0));
        vecs.push_back(mk("sltiu",   i_ins('h0B, 1, 4, 5),      32'h7,       32'h0,        32'h0,    5'b10100, 1, 32'h7,        32'h5,        4,  1, 0, 0, 0, 0));
        vecs.push_back(mk("slt",     r_ins(4, 5, 6, 0, 'h2A),  32'hFFFFFFFE, 32'h3,        32'h0,    5'b10011, 1, 32'hFFFFFFFE, 32'h3,        6,  1, 0, 0, 0, 0));
        vecs.push_back(mk("beq",     i_ins('h04, 1, 2, 'h10),  32'd11,       32'd22,       32'h0,    5'b01010, 1, 32'd11,       32'd22,       0,  0, 0, 0, 0, 0));
        vecs.push_back(mk("bgez",    i_ins('h01, 3, 1, 'h20),  32'hFFFFFFFF, 32'h9,        32'h0,    5'b01100, 1, 32'hFFFFFFFF, 32'h9,        0,  0, 0, 0, 0, 0));
        vecs.push_back(mk("bltz",    i_ins('h01, 3, 0, 'h20),  32'h5,        32'h9,        32'h0,    5'b01111, 1, 32'h5,        32'h9,        0,  0, 0, 0, 0, 0));
        vecs.push_back(mk("jal",     {6'h03, 26'h123},          32'h5,       32'h6,        32'h400,  5'b00000, 1, 32'h400,      32'h4,        31, 1, 0, 0, 0, 0));
        vecs.push_back(mk("j",       {6'h02, 26'h40},           32'h5,       32'h6,        32'h400,  5'b00000, 0, 32'h0,        32'h0,        0,  0, 0, 0, 0, 0));
        vecs.push_back(mk("jr",      r_ins(31, 0, 0, 0, 'h08), 32'h1000,     32'h0,        32'h0,    5'b01001, 1, 32'h1000,     32'h0,        0,  0, 0, 0, 0, 0));
        vecs.push_back(mk("add_r0",  r_ins(1, 2, 0, 0, 'h20),  32'h1,        32'h2,        32'h0,    5'b00000, 1, 32'h1,        32'h2,        0,  0, 0, 0, 1, 0));
        vecs.push_back(mk("ill_op",  {6'h3F, 26'h0},            32'h1,       32'h2,        32'h0,    5'b00000, 0, 32'h0,        32'h0,        0,  0, 0, 0, 0, 1));
        vecs.push_back(mk("ill_fn",  r_ins(1, 2, 3, 0, 'h3F),  32'h1,        32'h2,        32'h0,    5'b00000, 0, 32'h0,        32'h0,        0,  0, 0, 0, 0, 1));
        vecs.push_back(mk("sw",      i_ins('h2B, 6, 5, 8),     32'h100,      32'hDEAD,     32'h0,    5'b00000, 1, 32'h100,      32'h8,        0,  0, 0, 1, 0, 0));
        vecs.push_back(mk("nor",     r_ins(1, 2, 3, 0, 'h27),  32'hF0,       32'h0F,       32'h0,    5'b00100, 1, 32'hF0,       32'h0F,       3,  1, 0, 0, 0, 0));
        vecs.push_back(mk("lw",      i_ins('h23, 1, 4, 0),     32'h200,      32'h0,        32'h0,    5'b00000, 1, 32'h200,      32'h0,        4,  1, 1, 0, 0, 0));

        // Reset state, asserted and just after release
        #12;
        chk("rst ex_valid", 32'(ex_valid), 32'h0);
        chk("rst alu_code", 32'(ex_alu_code), 32'h0);
        chk("rst hazard_stall", 32'(hazard_stall), 32'h0);
        chk("rst reg_write", 32'(ex_reg_write), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post-rst ex_valid", 32'(ex_valid), 32'h0);
        chk("post-rst hazard_stall", 32'(hazard_stall), 32'h0);

        // Decode table; lw is last so no entry sees a load-use hazard
        foreach (vecs[i]) begin
            drive(vecs[i].instr, vecs[i].rs_d, vecs[i].rt_d, vecs[i].pc4);
            tick();
            chk({vecs[i].name, " valid"}, 32'(ex_valid), 32'h1);
            chk({vecs[i].name, " code"}, 32'(ex_alu_code), 32'(vecs[i].code));
            if (vecs[i].chk_ab) begin
                chk({vecs[i].name, " a"}, ex_alu_a, vecs[i].a);
                chk({vecs[i].name, " b"}, ex_alu_b, vecs[i].b);
            end
            if (vecs[i].mw)
                chk({vecs[i].name, " store"}, ex_store_data, vecs[i].rt_d);
            chk({vecs[i].name, " dst"}, 32'(ex_dst_reg), 32'(vecs[i].dst));
            chk({vecs[i].name, " reg_write"}, 32'(ex_reg_write), 32'(vecs[i].rw));
            chk({vecs[i].name, " mem_read"}, 32'(ex_mem_read), 32'(vecs[i].mr));
            chk({vecs[i].name, " mem_write"}, 32'(ex_mem_write), 32'(vecs[i].mw));
            chk({vecs[i].name, " ovf_trap"}, 32'(ex_ovf_trap), 32'(vecs[i].ovf));
            chk({vecs[i].name, " illegal"}, 32'(ex_illegal), 32'(vecs[i].ill));
        end
        idle();
        chk("idle valid", 32'(ex_valid), 32'h0);
        chk("idle reg_write", 32'(ex_reg_write), 32'h0);

        // lw $4 then add $7,$4,$4: one-cycle stall, one bubble, then add
        drive(i_ins('h23, 1, 4, 0), 32'h200, 32'h0, 32'h0);
        tick();
        drive(r_ins(4, 4, 7, 0, 'h20), 32'h11, 32'h22, 32'h0);
        #1;
        chk("lu stall", 32'(hazard_stall), 32'h1);
        tick();
        chk("lu bubble valid", 32'(ex_valid), 32'h0);
        chk("lu bubble reg_write", 32'(ex_reg_write), 32'h0);
        chk("lu bubble mem_read", 32'(ex_mem_read), 32'h0);
        chk("lu stall released", 32'(hazard_stall), 32'h0);
        tick();
        chk("lu add valid", 32'(ex_valid), 32'h1);
        chk("lu add dst", 32'(ex_dst_reg), 32'd7);
        chk("lu add reg_write", 32'(ex_reg_write), 32'h1);
        chk("lu add a", ex_alu_a, 32'h11);
        idle();

        // Dependency through rt of bne stalls; shamt shift and I-type rt do not
        drive(i_ins('h23, 1, 4, 0), 32'h200, 32'h0, 32'h0);
        tick();
        drive(i_ins('h05, 1, 4, 'h8), 32'h1, 32'h2, 32'h0);
        #1;
        chk("bne rt stall", 32'(hazard_stall), 32'h1);
        drive(r_ins(4, 2, 3, 4, 'h00), 32'h1, 32'h2, 32'h0);
        #1;
        chk("sll shamt no stall", 32'(hazard_stall), 32'h0);
        drive(i_ins('h08, 1, 4, 'h1), 32'h1, 32'h2, 32'h0);
        #1;
        chk("addi rt no stall", 32'(hazard_stall), 32'h0);
        // flush suppresses the stall and kills the instruction
        drive(r_ins(4, 4, 7, 0, 'h20), 32'h1, 32'h2, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush masks stall", 32'(hazard_stall), 32'h0);
        tick();
        flush = 1'b0;
        chk("flush bubble valid", 32'(ex_valid), 32'h0);
        chk("flush bubble reg_write", 32'(ex_reg_write), 32'h0);
        idle();

        // lw to $0 never stalls a dependent instruction
        drive(i_ins('h23, 1, 0, 0), 32'h200, 32'h0, 32'h0);
        tick();
        chk("lw r0 reg_write", 32'(ex_reg_write), 32'h0);
        drive(r_ins(0, 0, 7, 0, 'h20), 32'h0, 32'h0, 32'h0);
        #1;
        chk("lw r0 no stall", 32'(hazard_stall), 32'h0);
        tick();
        chk("lw r0 dep issues", 32'(ex_valid), 32'h1);
        chk("lw r0 dep dst", 32'(ex_dst_reg), 32'd7);
        idle();

        // ex_hold alone keeps everything; flush with ex_hold produces a bubble
        drive(r_ins(9, 10, 8, 0, 'h22), 32'd100, 32'd30, 32'h0);
        tick();
        drive(r_ins(1, 2, 3, 0, 'h27), 32'hF0, 32'h0F, 32'h0);
        ex_hold = 1'b1;
        tick();
        chk("hold valid", 32'(ex_valid), 32'h1);
        chk("hold code", 32'(ex_alu_code), 32'h05);
        chk("hold a", ex_alu_a, 32'd100);
        chk("hold b", ex_alu_b, 32'd30);
        chk("hold store", ex_store_data, 32'd30);
        chk("hold dst", 32'(ex_dst_reg), 32'd8);
        chk("hold reg_write", 32'(ex_reg_write), 32'h1);
        chk("hold ovf", 32'(ex_ovf_trap), 32'h1);
        flush = 1'b1;
        tick();
        chk("flush+hold valid", 32'(ex_valid), 32'h0);
        chk("flush+hold reg_write", 32'(ex_reg_write), 32'h0);
        chk("flush+hold ovf", 32'(ex_ovf_trap), 32'h0);
        flush = 1'b0;
        ex_hold = 1'b0;

        // Asynchronous reset mid-cycle clears EX without a clock edge
        drive(i_ins('h08, 0, 5, 'hFFFF), 32'h0, 32'h0, 32'h0);
        tick();
        chk("pre-async valid", 32'(ex_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(ex_valid), 32'h0);
        chk("async rst b", ex_alu_b, 32'h0);
        chk("async rst reg_write", 32'(ex_reg_write), 32'h0);
        chk("async rst ovf", 32'(ex_ovf_trap), 32'h0);
        #1;
        rst_n = 1'b1;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
